// File: rtl/julia_frame_scanner.sv
// Raster-order frame sequencer for the Julia iteration engine: loads each pixel's
// start coordinate, runs the engine (with a watchdog) and writes the colour out.
module julia_frame_scanner #(
  parameter int unsigned        H_RES   = 640,
  parameter int unsigned        V_RES   = 480,
  parameter int unsigned        ADDR_W  = 19,
  // Coordinates are Q8.24: -2.0 origin, 4.0-wide view split across the frame.
  parameter logic signed [31:0] X_START = -32'sd33554432,
  parameter logic signed [31:0] Y_START = -32'sd33554432,
  parameter logic signed [31:0] X_STEP  = 32'sd104858,
  parameter logic signed [31:0] Y_STEP  = 32'sd139810,
  parameter int unsigned        TIMEOUT = 65535
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  output logic                     calc_enable,
  output logic signed [31:0]       calc_x0,
  output logic signed [31:0]       calc_y0,
  input  logic                     calc_end,
  input  logic [15:0]              calc_color,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [15:0]              wr_data,
  input  logic                     wr_ready,
  output logic                     busy,
  output logic                     frame_done,
  output logic                     timeout_err
);

  localparam int XW = (H_RES > 1) ? $clog2(H_RES) : 1;
  localparam int YW = (V_RES > 1) ? $clog2(V_RES) : 1;
  localparam logic [XW-1:0] X_LAST  = XW'(H_RES - 1);
  localparam logic [YW-1:0] Y_LAST  = YW'(V_RES - 1);
  localparam logic [31:0]   WD_LAST = 32'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, WRITE, DONE} state_t;

  state_t                state_q, state_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  load_cnt_q, load_cnt_d;
  logic [31:0]           wd_cnt_q, wd_cnt_d;
  logic                  calc_enable_q, calc_enable_d;
  logic signed [31:0]    calc_x0_q, calc_x0_d;
  logic signed [31:0]    calc_y0_q, calc_y0_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]     wr_addr_q, wr_addr_d;
  logic [15:0]           wr_data_q, wr_data_d;
  logic                  busy_q, busy_d;
  logic                  frame_done_q, frame_done_d;
  logic                  timeout_err_q, timeout_err_d;

  always_comb begin
    state_d       = state_q;
    x_d           = x_q;
    y_d           = y_q;
    load_cnt_d    = load_cnt_q;
    wd_cnt_d      = wd_cnt_q;
    calc_enable_d = calc_enable_q;
    calc_x0_d     = calc_x0_q;
    calc_y0_d     = calc_y0_q;
    wr_en_d       = wr_en_q;
    wr_addr_d     = wr_addr_q;
    wr_data_d     = wr_data_q;
    frame_done_d  = 1'b0;
    timeout_err_d = timeout_err_q;

    case (state_q)
      IDLE: begin
        x_d           = '0;
        y_d           = '0;
        wr_addr_d     = '0;
        calc_x0_d     = X_START;
        calc_y0_d     = Y_START;
        calc_enable_d = 1'b0;
        wr_en_d       = 1'b0;
        if (start) begin
          state_d       = LOAD;
          load_cnt_d    = 1'b0;
          timeout_err_d = 1'b0;
        end
      end
      LOAD: begin
        if (load_cnt_q) begin
          state_d       = RUN;
          calc_enable_d = 1'b1;
          wd_cnt_d      = '0;
        end else begin
          load_cnt_d = 1'b1;
        end
      end
      RUN: begin
        // A finishing engine takes priority over a watchdog expiring in the same cycle.
        if (calc_end) begin
          wr_data_d     = calc_color;
          calc_enable_d = 1'b0;
          wr_en_d       = 1'b1;
          state_d       = WRITE;
        end else if (wd_cnt_q == WD_LAST) begin
          wr_data_d     = 16'h0000;
          timeout_err_d = 1'b1;
          calc_enable_d = 1'b0;
          wr_en_d       = 1'b1;
          state_d       = WRITE;
        end else begin
          wd_cnt_d = wd_cnt_q + 32'd1;
        end
      end
      WRITE: begin
        if (wr_ready) begin
          wr_en_d = 1'b0;
          if (x_q == X_LAST && y_q == Y_LAST) begin
            state_d      = DONE;
            frame_done_d = 1'b1;
          end else begin
            state_d    = LOAD;
            load_cnt_d = 1'b0;
            wr_addr_d  = wr_addr_q + ADDR_W'(1);
            if (x_q == X_LAST) begin
              x_d       = '0;
              y_d       = y_q + YW'(1);
              calc_x0_d = X_START;
              calc_y0_d = calc_y0_q + Y_STEP;
            end else begin
              x_d       = x_q + XW'(1);
              calc_x0_d = calc_x0_q + X_STEP;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      x_q           <= '0;
      y_q           <= '0;
      load_cnt_q    <= 1'b0;
      wd_cnt_q      <= '0;
      calc_enable_q <= 1'b0;
      calc_x0_q     <= X_START;
      calc_y0_q     <= Y_START;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      x_q           <= x_d;
      y_q           <= y_d;
      load_cnt_q    <= load_cnt_d;
      wd_cnt_q      <= wd_cnt_d;
      calc_enable_q <= calc_enable_d;
      calc_x0_q     <= calc_x0_d;
      calc_y0_q     <= calc_y0_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      timeout_err_q <= timeout_err_d;
    end
  end

  assign calc_enable = calc_enable_q;
  assign calc_x0     = calc_x0_q;
  assign calc_y0     = calc_y0_q;
  assign wr_en       = wr_en_q;
  assign wr_addr     = wr_addr_q;
  assign wr_data     = wr_data_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_julia_frame_scanner.sv
// Scoreboard bench: a 4x3 scanner driven by a coordinate-aware engine model, plus a
// 2x2 scanner used to exercise coordinate wrap-around.
module tb_julia_frame_scanner;

  localparam int H  = 4;
  localparam int V  = 3;
  localparam int TO = 20;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic               reset, start_a, start_b;
  logic               calc_enable_a, calc_end_a, wr_en_a, wr_ready_a, busy_a, frame_done_a, timeout_err_a;
  logic signed [31:0] calc_x0_a, calc_y0_a;
  logic [15:0]        calc_color_a, wr_data_a;
  logic [3:0]         wr_addr_a;

  logic               calc_enable_b, calc_end_b, wr_en_b, wr_ready_b, busy_b, frame_done_b, timeout_err_b;
  logic signed [31:0] calc_x0_b, calc_y0_b;
  logic [15:0]        calc_color_b, wr_data_b;
  logic [1:0]         wr_addr_b;

  julia_frame_scanner #(
    .H_RES(H), .V_RES(V), .ADDR_W(4),
    .X_START(32'sd100), .Y_START(-32'sd50), .X_STEP(32'sd10), .Y_STEP(-32'sd5),
    .TIMEOUT(TO)
  ) dut_a (
    .clk(clk), .reset(reset), .start(start_a),
    .calc_enable(calc_enable_a), .calc_x0(calc_x0_a), .calc_y0(calc_y0_a),
    .calc_end(calc_end_a), .calc_color(calc_color_a),
    .wr_en(wr_en_a), .wr_addr(wr_addr_a), .wr_data(wr_data_a), .wr_ready(wr_ready_a),
    .busy(busy_a), .frame_done(frame_done_a), .timeout_err(timeout_err_a)
  );

  julia_frame_scanner #(
    .H_RES(2), .V_RES(2), .ADDR_W(2),
    .X_START(32'sh7FFFFFF0), .Y_START(32'sd0), .X_STEP(32'sh10), .Y_STEP(32'sd1),
    .TIMEOUT(100)
  ) dut_b (
    .clk(clk), .reset(reset), .start(start_b),
    .calc_enable(calc_enable_b), .calc_x0(calc_x0_b), .calc_y0(calc_y0_b),
    .calc_end(calc_end_b), .calc_color(calc_color_b),
    .wr_en(wr_en_b), .wr_addr(wr_addr_b), .wr_data(wr_data_b), .wr_ready(wr_ready_b),
    .busy(busy_b), .frame_done(frame_done_b), .timeout_err(timeout_err_b)
  );

  // The wrap-test engine finishes on its first enabled cycle with a fixed colour.
  assign calc_end_b   = calc_enable_b;
  assign calc_color_b = 16'hBEEF;
  assign wr_ready_b   = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;
  wr_t exp_q[$];

  int         hang_idx = -1;
  int         bp_left  = 0;
  logic [3:0] bp_addr  = 4'd0;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic sa, input logic sb);
    @(posedge clk); #1;
    start_a = sa;
    start_b = sb;
    @(posedge clk); #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_calc_enable"}, 32'(calc_enable_a), 32'd0);
    checkOutput({tag, "_calc_x0"}, calc_x0_a, 32'd100);
    checkOutput({tag, "_calc_y0"}, calc_y0_a, 32'hFFFFFFCE);
    checkOutput({tag, "_wr_en"}, 32'(wr_en_a), 32'd0);
    checkOutput({tag, "_wr_addr"}, 32'(wr_addr_a), 32'd0);
    checkOutput({tag, "_wr_data"}, 32'(wr_data_a), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy_a), 32'd0);
    checkOutput({tag, "_frame_done"}, 32'(frame_done_a), 32'd0);
    checkOutput({tag, "_timeout_err"}, 32'(timeout_err_a), 32'd0);
  endtask

  task automatic waitFrameDone(input string tag);
    for (int i = 0; i < 2000 && !frame_done_a; i++) begin
      @(posedge clk); #1;
    end
    checkOutput({tag, "_frame_done_seen"}, 32'(frame_done_a), 32'd1);
    @(negedge clk);
    @(negedge clk);
  endtask

  // Pixel index recovered from the presented coordinates (x0=100+10x, y0=-50-5y).
  function automatic int pixIdx();
    return ((-50 - int'(calc_y0_a)) / 5) * H + (int'(calc_x0_a) - 100) / 10;
  endfunction

  // Engine model: clears while disabled, reports colour = pixel index after 5 enabled cycles.
  int eng_cnt = 0;
  initial begin
    calc_end_a   = 1'b0;
    calc_color_a = 16'h0;
    forever begin
      @(posedge clk); #1;
      if (!calc_enable_a) begin
        eng_cnt    = 0;
        calc_end_a = 1'b0;
      end else begin
        eng_cnt++;
        if (eng_cnt >= 5 && pixIdx() != hang_idx) begin
          calc_end_a   = 1'b1;
          calc_color_a = 16'(pixIdx());
        end
      end
    end
  end

  // Frame-buffer back-pressure: holds ready low for bp_left cycles of the chosen write.
  initial begin
    wr_ready_a = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (wr_en_a && wr_addr_a == bp_addr && bp_left > 0) begin
        wr_ready_a = 1'b0;
        bp_left--;
      end else begin
        wr_ready_a = 1'b1;
      end
    end
  end

  // Write monitor: scoreboard pop on transfer, stability under stall, pulse bookkeeping.
  int          writes = 0;
  int          stall_cycles = 0;
  int          fd_pulses = 0;
  logic        prev_stall = 1'b0;
  logic        prev_fd = 1'b0;
  logic [3:0]  hold_addr;
  logic [15:0] hold_data;
  wr_t         e;
  always @(negedge clk) begin
    if (wr_en_a && !wr_ready_a) begin
      if (!prev_stall) begin
        hold_addr = wr_addr_a;
        hold_data = wr_data_a;
      end else begin
        checkOutput("stall_addr", 32'(wr_addr_a), 32'(hold_addr));
        checkOutput("stall_data", 32'(wr_data_a), 32'(hold_data));
      end
      stall_cycles++;
    end
    prev_stall = wr_en_a && !wr_ready_a;
    if (wr_en_a && wr_ready_a) begin
      writes++;
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL unexpected_write: got addr %0h data %0h, expected no write", wr_addr_a, wr_data_a);
      end else begin
        e = exp_q.pop_front();
        checkOutput("wr_addr", 32'(wr_addr_a), 32'(e.addr));
        checkOutput("wr_data", 32'(wr_data_a), 32'(e.data));
      end
    end
    if (prev_fd) checkOutput("busy_after_done", 32'(busy_a), 32'd0);
    if (frame_done_a) fd_pulses++;
    prev_fd = frame_done_a;
  end

  // Coordinate monitor: each RUN entry follows exactly two LOAD cycles with the right x0/y0.
  int   load_cyc = 0;
  int   run_cyc = 0;
  int   cpix = 0;
  logic prev_en = 1'b0;
  logic prev_busy = 1'b0;
  always @(negedge clk) begin
    if (busy_a && !prev_busy) begin
      cpix     = 0;
      load_cyc = 0;
    end
    if (busy_a && !calc_enable_a && !wr_en_a && !frame_done_a) load_cyc++;
    if (calc_enable_a && !prev_en) begin
      checkOutput("load_cycles", 32'(load_cyc), 32'd2);
      checkOutput("calc_x0", calc_x0_a, 32'(100 + 10 * (cpix % H)));
      checkOutput("calc_y0", calc_y0_a, 32'(-50 - 5 * (cpix / H)));
      run_cyc = 0;
    end
    if (calc_enable_a) run_cyc++;
    if (!calc_enable_a && prev_en) begin
      if (cpix == hang_idx) checkOutput("timeout_run_cycles", 32'(run_cyc), 32'(TO));
      cpix++;
      load_cyc = 0;
    end
    prev_en   = calc_enable_a;
    prev_busy = busy_a;
  end

  // Wrap-test monitor: second pixel's x0 overflows to the most negative value.
  int   b_writes = 0;
  int   b_runs = 0;
  logic prev_en_b = 1'b0;
  always @(negedge clk) begin
    if (calc_enable_b && !prev_en_b) begin
      if (b_runs == 0) checkOutput("b_x0_first", calc_x0_b, 32'h7FFFFFF0);
      else if (b_runs == 1) checkOutput("b_x0_wrap", calc_x0_b, 32'h80000000);
      b_runs++;
    end
    if (wr_en_b) begin
      checkOutput("b_wr_addr", 32'(wr_addr_b), 32'(b_writes));
      checkOutput("b_wr_data", 32'(wr_data_b), 32'hBEEF);
      b_writes++;
    end
    prev_en_b = calc_enable_b;
  end

  initial begin
    #100000;
    $display("[TB] FAIL global_timeout: simulation did not complete, expected completion");
    $fatal(1, "[TB] global timeout");
  end

  initial begin
    reset   = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    checkResetValues("reset");

    // Frame 1: plain render with a 7-cycle stall on pixel 2 and a stray mid-frame start.
    for (int i = 0; i < H * V; i++) exp_q.push_back('{addr: 4'(i), data: 16'(i)});
    bp_addr = 4'd2;
    bp_left = 7;
    applyStimulus(1'b1, 1'b1);
    @(negedge clk);
    checkOutput("busy_cycle1", 32'(busy_a), 32'd1);
    checkOutput("enable_cycle1", 32'(calc_enable_a), 32'd0);
    @(negedge clk);
    checkOutput("enable_cycle2", 32'(calc_enable_a), 32'd0);
    @(negedge clk);
    checkOutput("enable_cycle3", 32'(calc_enable_a), 32'd1);
    for (int i = 0; i < 1000 && wr_addr_a != 4'd5; i++) begin
      @(posedge clk); #1;
    end
    checkOutput("reached_addr5", 32'(wr_addr_a), 32'd5);
    applyStimulus(1'b1, 1'b0);
    waitFrameDone("frame1");
    checkOutput("frame1_writes", 32'(writes), 32'd12);
    checkOutput("frame1_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("frame1_done_pulses", 32'(fd_pulses), 32'd1);
    checkOutput("frame1_stall_cycles", 32'(stall_cycles), 32'd7);
    checkOutput("frame1_timeout_err", 32'(timeout_err_a), 32'd0);
    checkOutput("b_write_count", 32'(b_writes), 32'd4);

    // Frame 2: the engine hangs on pixel 1, so the watchdog writes black and flags an error.
    writes    = 0;
    fd_pulses = 0;
    hang_idx  = 1;
    for (int i = 0; i < H * V; i++) exp_q.push_back('{addr: 4'(i), data: (i == 1) ? 16'h0 : 16'(i)});
    applyStimulus(1'b1, 1'b0);
    waitFrameDone("frame2");
    checkOutput("frame2_writes", 32'(writes), 32'd12);
    checkOutput("frame2_queue_empty", 32'(exp_q.size()), 32'd0);
    checkOutput("frame2_done_pulses", 32'(fd_pulses), 32'd1);
    checkOutput("frame2_timeout_err", 32'(timeout_err_a), 32'd1);

    // Frame 3: a new start clears the error; reset during RUN aborts with no write.
    hang_idx = -1;
    writes   = 0;
    applyStimulus(1'b1, 1'b0);
    @(negedge clk);
    checkOutput("timeout_err_cleared", 32'(timeout_err_a), 32'd0);
    for (int i = 0; i < 50 && !calc_enable_a; i++) @(negedge clk);
    checkOutput("frame3_in_run", 32'(calc_enable_a), 32'd1);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetValues("midreset");
    reset = 1'b0;
    repeat (30) @(posedge clk);
    @(negedge clk);
    checkOutput("post_reset_busy", 32'(busy_a), 32'd0);
    checkOutput("post_reset_writes", 32'(writes), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
